// File: rtl/mux_pkg.sv
// ----------------------------------------------------------------------------
// mux_pkg : shared select width, channel count and select codes for 4:1 muxes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mux_pkg;

  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_I0 = 2'd0;
  localparam sel_t SEL_I1 = 2'd1;
  localparam sel_t SEL_I2 = 2'd2;
  localparam sel_t SEL_I3 = 2'd3;

endpackage : mux_pkg

`default_nettype wire

// File: rtl/mux_4_1_core.sv
// ----------------------------------------------------------------------------
// mux_4_1_core : combinational 4-way channel select plus one-hot select decode
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mux_4_1_core
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [NUM_IN*WIDTH-1:0] i_data,
  input  sel_t                    i_sel,
  output logic [WIDTH-1:0]        o_y,
  output logic [NUM_IN-1:0]       o_sel_oh
);

  logic [WIDTH-1:0] w_chan [NUM_IN];

  for (genvar k = 0; k < NUM_IN; k++) begin : g_chan
    assign w_chan[k] = i_data[k*WIDTH +: WIDTH];
  end

  // A select carrying X/Z matches no case item, so both outputs stay at zero.
  always_comb begin
    o_y      = '0;
    o_sel_oh = '0;
    case (i_sel)
      SEL_I0: begin o_y = w_chan[0]; o_sel_oh = 4'b0001; end
      SEL_I1: begin o_y = w_chan[1]; o_sel_oh = 4'b0010; end
      SEL_I2: begin o_y = w_chan[2]; o_sel_oh = 4'b0100; end
      SEL_I3: begin o_y = w_chan[3]; o_sel_oh = 4'b1000; end
      default: begin o_y = '0; o_sel_oh = '0; end
    endcase
  end

endmodule : mux_4_1_core

`default_nettype wire

// File: rtl/mux_4_1_s.sv
// ----------------------------------------------------------------------------
// mux_4_1_s : 4:1 selector with combinational output and en-gated registered copy
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mux_4_1_s
  import mux_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] I,
  input  logic [SEL_W-1:0]        s,
  input  logic                    en,
  output logic [WIDTH-1:0]        Y,
  output logic [WIDTH-1:0]        Y_q,
  output logic [NUM_IN-1:0]       sel_oh
);

  logic [WIDTH-1:0]  w_y;
  logic [NUM_IN-1:0] w_sel_oh;
  logic [WIDTH-1:0]  r_y_q;

  mux_4_1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_data   (I),
    .i_sel    (s),
    .o_y      (w_y),
    .o_sel_oh (w_sel_oh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q <= RESET_VAL;
    end else if (en) begin
      r_y_q <= w_y;
    end
  end

  assign Y      = w_y;
  assign sel_oh = w_sel_oh;
  assign Y_q    = r_y_q;

endmodule : mux_4_1_s

`default_nettype wire

// File: tb/tb_mux_4_1_s.sv
// ----------------------------------------------------------------------------
// tb_mux_4_1_s : self-checking bench for mux_4_1_s at WIDTH=1 and WIDTH=8
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mux_4_1_s;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  I1;
  logic [1:0]  s1;
  logic        en1;
  logic        Y1, Yq1;
  logic [3:0]  oh1;

  logic [31:0] I8;
  logic [1:0]  s8;
  logic        en8;
  logic [7:0]  Y8, Yq8;
  logic [3:0]  oh8;

  int errors = 0;
  int checks = 0;

  logic       exp1_q [$];
  logic [7:0] exp8_q [$];

  mux_4_1_s #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .I(I1), .s(s1), .en(en1),
    .Y(Y1), .Y_q(Yq1), .sel_oh(oh1)
  );

  mux_4_1_s #(.WIDTH(8), .RESET_VAL(8'h5A)) dut8 (
    .clk(clk), .rst_n(rst_n), .I(I8), .s(s8), .en(en8),
    .Y(Y8), .Y_q(Yq8), .sel_oh(oh8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop1(input string name);
    if (exp1_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: got empty-queue expected entry", name);
    end else begin
      chk(name, {31'd0, Yq1}, {31'd0, exp1_q.pop_front()});
    end
  endtask

  task automatic pop8(input string name);
    if (exp8_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: got empty-queue expected entry", name);
    end else begin
      chk(name, {24'd0, Yq8}, {24'd0, exp8_q.pop_front()});
    end
  endtask

  typedef struct {
    logic [3:0] i;
    logic [1:0] s;
    logic       y;
    logic [3:0] oh;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{4'b0000, 2'b00, 1'b0, 4'b0001};
    vecs[1]  = '{4'b0001, 2'b00, 1'b1, 4'b0001};
    vecs[2]  = '{4'b0000, 2'b01, 1'b0, 4'b0010};
    vecs[3]  = '{4'b0010, 2'b01, 1'b1, 4'b0010};
    vecs[4]  = '{4'b0000, 2'b10, 1'b0, 4'b0100};
    vecs[5]  = '{4'b0100, 2'b10, 1'b1, 4'b0100};
    vecs[6]  = '{4'b0000, 2'b11, 1'b0, 4'b1000};
    vecs[7]  = '{4'b1000, 2'b11, 1'b1, 4'b1000};
    // channel-isolation sweep with channel 1 held low, then raised
    vecs[8]  = '{4'b1101, 2'b01, 1'b0, 4'b0010};
    vecs[9]  = '{4'b0101, 2'b01, 1'b0, 4'b0010};
    vecs[10] = '{4'b1001, 2'b01, 1'b0, 4'b0010};
    vecs[11] = '{4'b1101, 2'b01, 1'b0, 4'b0010};
    vecs[12] = '{4'b1111, 2'b01, 1'b1, 4'b0010};
    vecs[13] = '{4'b0111, 2'b00, 1'b1, 4'b0001};

    rst_n = 1'b1; en1 = 1'b0; en8 = 1'b0;
    I1 = '0; s1 = '0; I8 = '0; s8 = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_yq1", {31'd0, Yq1}, 32'd0);
    chk("reset_yq8", {24'd0, Yq8}, 32'h5A);

    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      I1 = vecs[n].i;
      s1 = vecs[n].s;
      #1;
      chk($sformatf("tt_y[%0d]", n),  {31'd0, Y1}, {31'd0, vecs[n].y});
      chk($sformatf("tt_oh[%0d]", n), {28'd0, oh1}, {28'd0, vecs[n].oh});
      chk($sformatf("tt_yq_rst[%0d]", n), {31'd0, Yq1}, 32'd0);
    end

    // registered path: release reset, capture, then hold with en=0
    @(negedge clk);
    rst_n = 1'b1;
    I1 = 4'b0100; s1 = 2'b10; en1 = 1'b1;
    exp1_q.push_back(1'b1);
    @(posedge clk); #1;
    pop1("reg_capture");
    @(negedge clk);
    en1 = 1'b0; s1 = 2'b00;
    #1;
    chk("hold_y", {31'd0, Y1}, 32'd0);
    @(posedge clk); #1;
    chk("hold_yq", {31'd0, Yq1}, 32'd1);
    @(posedge clk); #1;
    chk("hold_yq2", {31'd0, Yq1}, 32'd1);

    // WIDTH=8 walk; each Y_q is compared one edge after its select is driven
    @(negedge clk);
    I8 = 32'hD4C3B2A1; en8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] exp_y;
      exp_y = (k == 0) ? 8'hA1 : (k == 1) ? 8'hB2 : (k == 2) ? 8'hC3 : 8'hD4;
      @(negedge clk);
      s8 = 2'(k);
      #1;
      chk($sformatf("w8_y[%0d]", k), {24'd0, Y8}, {24'd0, exp_y});
      chk($sformatf("w8_oh[%0d]", k), {28'd0, oh8}, 32'(1 << k));
      exp8_q.push_back(exp_y);
      @(posedge clk); #1;
      pop8($sformatf("w8_yq[%0d]", k));
    end
    @(negedge clk);
    en8 = 1'b0; s8 = 2'b00;
    @(posedge clk); #1;
    chk("w8_hold", {24'd0, Yq8}, 32'hD4);

    // asynchronous reset mid-cycle, no clock edge involved
    @(negedge clk);
    en1 = 1'b1; I1 = 4'b0100; s1 = 2'b10;
    @(posedge clk); #1;
    chk("pre_async_yq", {31'd0, Yq1}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_yq1", {31'd0, Yq1}, 32'd0);
    chk("async_yq8", {24'd0, Yq8}, 32'h5A);
    s1 = 2'b11; I1 = 4'b1000;
    #1;
    chk("rst_y_follow", {31'd0, Y1}, 32'd1);
    chk("rst_oh_follow", {28'd0, oh1}, 32'b1000);
    @(posedge clk); #1;
    chk("rst_override_en", {31'd0, Yq1}, 32'd0);

    // X select: Y is zero; chosen data keeps Y zero even if X is collapsed
    @(negedge clk);
    I1 = 4'b0101;
    s1 = 2'bx1;
    #1;
    chk("xsel_y", {31'd0, Y1}, 32'd0);
    if ($isunknown(s1)) chk("xsel_oh", {28'd0, oh1}, 32'd0);
    @(negedge clk);
    s1 = 2'b11; I1 = 4'b1000;
    #1;
    chk("after_x_y", {31'd0, Y1}, 32'd1);
    chk("after_x_oh", {28'd0, oh1}, 32'b1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no-finish expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_mux_4_1_s

`default_nettype wire
